uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter N, default 8: data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16: rx_en ticks per bit period; even, >= 4.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 rx_en  input  1: oversample tick, one-clk pulse at OVERSAMPLE x baud rate.
REQ-006 rx_in  input  1: serial line; idles high; asynchronous to clk.
REQ-007 read_en  input  1: consumer acknowledge; clears rx_ready and overrun.
REQ-008 rx_out  output  N: last accepted data byte.
REQ-009 rx_ready  output  1: rx_out holds an unread byte.
REQ-010 frame_err  output  1: one-clk pulse when a stop bit is sampled low.
REQ-011 overrun  output  1: sticky flag; a frame completed while rx_ready was high.
REQ-012 busy  output  1: high whenever state is not IDLE.

Function
REQ-013 rx_in SHALL pass through a 2-flop synchronizer, reset to 1; all sampling SHALL use the synchronized value (rx_s).
REQ-014 Frame format SHALL be: 1 start bit (0), N data bits LSB first, 1 stop bit (1).
REQ-015 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-016 Tick counter cnt (0..OVERSAMPLE-1) SHALL change only on rx_en cycles and SHALL clear on every state change.
REQ-017 IDLE->START SHALL occur on a falling edge of rx_s (previous 1, current 0), independent of rx_en.
REQ-018 START: on the rx_en tick where cnt==OVERSAMPLE/2-1, the FSM SHALL sample rx_s.
- 0: go to DATA with bit index=0.
- 1: treat as a glitch and return to IDLE with no output activity.
REQ-019 DATA: on the rx_en tick where cnt==OVERSAMPLE-1, the FSM SHALL store rx_s into shift[index].
- index<N-1: increment index.
- index==N-1: go to STOP.
REQ-020 STOP: on the rx_en tick where cnt==OVERSAMPLE-1, the FSM SHALL sample the stop bit and go to IDLE.
REQ-021 Stop bit sampled 1 with rx_ready low, or with read_en high that cycle: the byte SHALL load into rx_out and rx_ready SHALL be high on the next clk.
REQ-022 Stop bit sampled 1 with rx_ready high and read_en low: rx_out and rx_ready SHALL be kept, the new byte dropped, and overrun set.
REQ-023 Stop bit sampled 0: frame_err SHALL pulse one clk, and rx_out, rx_ready and overrun SHALL be unchanged.
REQ-024 After any STOP exit, a new frame SHALL start only on a fresh falling edge, so a held-low break line does not retrigger.
REQ-025 read_en with rx_ready high SHALL clear rx_ready and overrun on the next clk; read_en with rx_ready low SHALL have no effect.
REQ-026 rx_en high while in IDLE SHALL have no effect.
REQ-027 Receive latency SHALL be: rx_ready rises 1 clk after the mid-stop-bit rx_en tick.

Reset
REQ-028 While reset is low, outputs SHALL be: rx_out=0, rx_ready=0, frame_err=0, overrun=0, busy=0.
REQ-029 While reset is low, internal state SHALL be: state=IDLE, cnt=0, index=0, shift=0, synchronizer flops=1.
REQ-030 Reset assertion mid-frame SHALL abort the frame immediately with no rx_ready or frame_err pulse.
REQ-031 After reset deassertion, reception SHALL require a new falling edge.

Verification
REQ-032 rx_en every clk, line sends 0xA5 with a valid stop bit -> rx_out=0xA5, rx_ready=1, frame_err=0, busy=0 after the frame.
REQ-033 rx_en every 3rd clk, bytes 0x00 then 0xFF back-to-back, read_en after each -> both received in order, overrun=0.
REQ-034 rx_in low for 4 rx_en ticks, then high -> return to IDLE; rx_ready, frame_err and busy all 0 afterward.
REQ-035 0x3C sent with stop bit 0, then line held low for 3 frames -> exactly one frame_err pulse, rx_ready=0, busy=0 while the line stays low.
REQ-036 0x11 received and not read, then 0x22 received -> rx_out=0x11, overrun=1; read_en -> rx_ready=0, overrun=0.
REQ-037 Two cases:
- read_en in the same cycle as 0x22 completes (after unread 0x11) -> rx_out=0x22, rx_ready=1, overrun=0.
- reset pulsed low during data bit 4 -> all outputs 0; next full frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART: oversample tick, serial line, consumer handshake and status.
interface uart_rx_if #(
  parameter int N = 8
);
  logic         rx_en;
  logic         rx_in;
  logic         read_en;
  logic [N-1:0] rx_out;
  logic         rx_ready;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  modport slave (
    input  rx_en, rx_in, read_en,
    output rx_out, rx_ready, frame_err, overrun, busy
  );

  modport master (
    output rx_en, rx_in, read_en,
    input  rx_out, rx_ready, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 1 start bit, N data bits LSB first, 1 stop bit,
// single-entry output holding register with overrun and framing-error reporting.
module uart_rx #(
  parameter int N          = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_END = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_sync1, r_sync2, r_prev;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [N-1:0]  r_shift;
  logic [N-1:0]  r_rx_out;
  logic          r_rx_ready, r_frame_err, r_overrun, r_busy;
  logic          w_rx_s, w_fall, w_mid_tick, w_end_tick, w_ack;
  logic          w_shift_en, w_idx_clr, w_idx_inc, w_load, w_ovr_set, w_ferr;

  assign w_rx_s     = r_sync2;
  assign w_fall     = r_prev & ~r_sync2;
  assign w_mid_tick = bus.rx_en & (r_cnt == CNT_MID);
  assign w_end_tick = bus.rx_en & (r_cnt == CNT_END);
  assign w_ack      = bus.read_en & r_rx_ready;

  // Two-flop synchronizer plus one history flop; a held-low line never produces a new edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= bus.rx_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_state_nxt = START; else w_state_nxt = IDLE;
      START:   if (w_mid_tick) w_state_nxt = w_rx_s ? IDLE : DATA; else w_state_nxt = START;
      DATA:    if (w_end_tick && (r_idx == IDX_END)) w_state_nxt = STOP; else w_state_nxt = DATA;
      STOP:    if (w_end_tick) w_state_nxt = IDLE; else w_state_nxt = STOP;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs; a completed byte loads only if the holding register is free or being read now
  always_comb begin
    w_shift_en = 1'b0;
    w_idx_clr  = 1'b0;
    w_idx_inc  = 1'b0;
    w_load     = 1'b0;
    w_ovr_set  = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      START: begin
        w_idx_clr = w_mid_tick & ~w_rx_s;
      end
      DATA: begin
        w_shift_en = w_end_tick;
        w_idx_inc  = w_end_tick & (r_idx != IDX_END);
      end
      STOP: begin
        w_load    = w_end_tick & w_rx_s & (~r_rx_ready | bus.read_en);
        w_ovr_set = w_end_tick & w_rx_s & r_rx_ready & ~bus.read_en;
        w_ferr    = w_end_tick & ~w_rx_s;
      end
      default: begin
        w_shift_en = 1'b0;
      end
    endcase
  end

  // Tick counter: advances only on rx_en, cleared on every state change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= {CW{1'b0}};
    end else if (w_state_nxt != r_state) begin
      r_cnt <= {CW{1'b0}};
    end else if (bus.rx_en && (r_state != IDLE)) begin
      r_cnt <= (r_cnt == CNT_END) ? {CW{1'b0}} : r_cnt + CW'(1);
    end
  end

  // Bit index and shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx   <= {IW{1'b0}};
      r_shift <= {N{1'b0}};
    end else begin
      if (w_idx_clr) begin
        r_idx <= {IW{1'b0}};
      end else if (w_idx_inc) begin
        r_idx <= r_idx + IW'(1);
      end
      if (w_shift_en) begin
        r_shift[r_idx] <= w_rx_s;
      end
    end
  end

  // Registered outputs; a simultaneous load and read leaves rx_ready set and clears overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_out    <= {N{1'b0}};
      r_rx_ready  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_busy      <= (w_state_nxt != IDLE);
      if (w_load) begin
        r_rx_out <= r_shift;
      end
      if (w_load) begin
        r_rx_ready <= 1'b1;
      end else if (w_ack) begin
        r_rx_ready <= 1'b0;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (w_ack) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.rx_out    = r_rx_out;
  assign bus.rx_ready  = r_rx_ready;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx; expected results come from a frame-level
// model of the receive holding register (load / overrun / framing error / read).
module tb_uart_rx;
  localparam int N     = 8;
  localparam int OS    = 16;
  localparam int FRAME = (N + 2) * OS;

  logic         clk;
  logic         reset;
  int           total     = 0;
  int           bad       = 0;
  int           en_div    = 1;
  int           tk_cnt    = 0;
  int           stop_base = 0;
  int           rise_tick = -1000;
  int           k_stop    = -1;
  int           ferr_cnt  = 0;
  logic         rdy_q     = 1'b0;
  logic [N-1:0] m_out     = '0;
  logic         m_ready   = 1'b0;
  logic         m_ovr     = 1'b0;
  int           m_ferr    = 0;

  uart_rx_if #(.N(N)) bus ();
  uart_rx #(.N(N), .OVERSAMPLE(OS)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: observe the previous edge's results, then drive the next edge's inputs.
  task automatic cyc(input logic en, input logic rd);
    @(negedge clk);
    if (bus.rx_en) tk_cnt++;
    if (bus.frame_err) ferr_cnt++;
    if (reset && bus.rx_ready && !rdy_q) begin
      rise_tick = tk_cnt - 1;
      total++;
      if (bus.rx_en !== 1'b1) begin
        bad++;
        $display("FAIL ready_latency: rx_en on preceding edge=%b want 1", bus.rx_en);
      end
    end
    rdy_q = bus.rx_ready;
    bus.rx_en   = en;
    bus.read_en = rd;
  endtask

  task automatic tick(input logic rd);
    for (int i = 1; i < en_div; i++) cyc(1'b0, 1'b0);
    cyc(1'b1, rd);
  endtask

  task automatic hold(input logic b, input int n);
    bus.rx_in = b;
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic do_read();
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    if (m_ready) begin
      m_ready = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  // Full frame; rd_at >= 0 pulses read_en on that rx_en tick of the stop bit.
  task automatic send_frame(input logic [N-1:0] d, input logic stop, input int rd_at);
    hold(1'b0, OS);
    for (int b = 0; b < N; b++) hold(d[b], OS);
    bus.rx_in = stop;
    for (int t = 0; t < OS; t++) begin
      tick(t == rd_at);
      if (t == 0) stop_base = tk_cnt;
    end
    bus.rx_in = 1'b1;
    cyc(1'b0, 1'b0);
    if (rd_at >= 0) begin
      m_ready = 1'b0;
      m_ovr   = 1'b0;
    end
    if (stop) begin
      if (!m_ready) begin
        m_out   = d;
        m_ready = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      m_ferr++;
    end
  endtask

  task automatic test_reset();
    repeat (3) cyc(1'b1, 1'b0);
    total++; if (bus.rx_out !== {N{1'b0}}) begin bad++; $display("FAIL reset_rx_out: got %h want 0", bus.rx_out); end
    total++; if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready: got %b want 0", bus.rx_ready); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    cyc(1'b0, 1'b0);
    reset = 1'b1;
    hold(1'b1, 4);
  endtask

  task automatic test_basic();
    en_div = 1;
    send_frame(8'hA5, 1'b1, -1);
    total++; if (bus.rx_out !== m_out) begin bad++; $display("FAIL basic_rx_out: got %h want %h", bus.rx_out, m_out); end
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL basic_rx_ready: got %b want 1", bus.rx_ready); end
    total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL basic_frame_err: got %0d want %0d", ferr_cnt, m_ferr); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b want 0", bus.busy); end
    k_stop = rise_tick - stop_base;
    total++; if (k_stop < 0 || k_stop >= OS) begin bad++; $display("FAIL basic_stop_phase: got %0d want 0..%0d", k_stop, OS - 1); end
    do_read();
    total++; if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL basic_read_clear: got %b want 0", bus.rx_ready); end
    hold(1'b1, 4);
  endtask

  task automatic test_back_to_back();
    en_div = 3;
    send_frame(8'h00, 1'b1, -1);
    total++; if (bus.rx_out !== m_out || bus.rx_ready !== 1'b1) begin bad++; $display("FAIL b2b_first: got %h/%b want %h/1", bus.rx_out, bus.rx_ready, m_out); end
    do_read();
    send_frame(8'hFF, 1'b1, -1);
    total++; if (bus.rx_out !== m_out || bus.rx_ready !== 1'b1) begin bad++; $display("FAIL b2b_second: got %h/%b want %h/1", bus.rx_out, bus.rx_ready, m_out); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got %b want 0", bus.overrun); end
    do_read();
    hold(1'b1, 4);
  endtask

  task automatic test_glitch();
    en_div = 2;
    do_read();
    hold(1'b0, 4);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_start: got %b want 1", bus.busy); end
    hold(1'b1, 2 * OS);
    total++; if (bus.busy !== 1'b0 || bus.rx_ready !== 1'b0) begin bad++; $display("FAIL glitch_idle: busy/ready got %b/%b want 0/0", bus.busy, bus.rx_ready); end
    total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL glitch_frame_err: got %0d want %0d", ferr_cnt, m_ferr); end
  endtask

  task automatic test_break();
    logic [N-1:0] d;
    d = 8'h3C;
    en_div = 1;
    do_read();
    hold(1'b0, OS);
    for (int b = 0; b < N; b++) hold(d[b], OS);
    hold(1'b0, OS);
    m_ferr++;
    for (int f = 0; f < 3; f++) begin
      hold(1'b0, FRAME);
      total++; if (bus.busy !== 1'b0 || bus.rx_ready !== 1'b0) begin bad++; $display("FAIL break_low_%0d: busy/ready got %b/%b want 0/0", f, bus.busy, bus.rx_ready); end
    end
    hold(1'b1, 4);
    total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL break_frame_err: got %0d want %0d", ferr_cnt, m_ferr); end
    total++; if (bus.rx_out !== m_out) begin bad++; $display("FAIL break_rx_out: got %h want %h", bus.rx_out, m_out); end
  endtask

  task automatic test_overrun();
    en_div = 2;
    do_read();
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    total++; if (bus.rx_out !== m_out) begin bad++; $display("FAIL ovr_rx_out: got %h want %h", bus.rx_out, m_out); end
    total++; if (bus.overrun !== m_ovr || bus.rx_ready !== m_ready) begin bad++; $display("FAIL ovr_flags: ovr/ready got %b/%b want %b/%b", bus.overrun, bus.rx_ready, m_ovr, m_ready); end
    do_read();
    total++; if (bus.overrun !== 1'b0 || bus.rx_ready !== 1'b0) begin bad++; $display("FAIL ovr_read: ovr/ready got %b/%b want 0/0", bus.overrun, bus.rx_ready); end
    hold(1'b1, 4);
  endtask

  task automatic test_same_cycle_read();
    en_div = 1;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, k_stop);
    total++; if (bus.rx_out !== m_out) begin bad++; $display("FAIL same_rd_rx_out: got %h want %h", bus.rx_out, m_out); end
    total++; if (bus.rx_ready !== 1'b1 || bus.overrun !== 1'b0) begin bad++; $display("FAIL same_rd_flags: ready/ovr got %b/%b want 1/0", bus.rx_ready, bus.overrun); end
    do_read();
    hold(1'b1, 4);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] d;
    d = 8'h5A;
    en_div = 1;
    hold(1'b0, OS);
    for (int b = 0; b < 4; b++) hold(d[b], OS);
    hold(d[4], OS / 2);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", bus.busy); end
    cyc(1'b0, 1'b0);
    reset = 1'b0;
    m_out = '0; m_ready = 1'b0; m_ovr = 1'b0;
    cyc(1'b1, 1'b0);
    bus.rx_in = 1'b1;
    cyc(1'b1, 1'b0);
    total++; if (bus.rx_out !== {N{1'b0}} || bus.rx_ready !== 1'b0 || bus.overrun !== 1'b0 || bus.busy !== 1'b0 || bus.frame_err !== 1'b0)
      begin bad++; $display("FAIL rstmid_outputs: out/rdy/ovr/busy/ferr got %h/%b/%b/%b/%b want 0", bus.rx_out, bus.rx_ready, bus.overrun, bus.busy, bus.frame_err); end
    cyc(1'b0, 1'b0);
    reset = 1'b1;
    hold(1'b1, 2 * OS);
    total++; if (bus.rx_ready !== 1'b0 || bus.busy !== 1'b0 || ferr_cnt !== m_ferr) begin bad++; $display("FAIL rstmid_quiet: rdy/busy/ferr got %b/%b/%0d want 0/0/%0d", bus.rx_ready, bus.busy, ferr_cnt, m_ferr); end
    send_frame(d, 1'b1, -1);
    total++; if (bus.rx_out !== m_out || bus.rx_ready !== 1'b1) begin bad++; $display("FAIL rstmid_next_frame: got %h/%b want %h/1", bus.rx_out, bus.rx_ready, m_out); end
    do_read();
    hold(1'b1, 4);
  endtask

  task automatic test_random();
    logic [N-1:0] d;
    logic         stop;
    for (int f = 0; f < 16; f++) begin
      en_div = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) do_read();
      d    = N'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop, -1);
      total++; if (bus.rx_out !== m_out) begin bad++; $display("FAIL rand_%0d_rx_out: got %h want %h", f, bus.rx_out, m_out); end
      total++; if (bus.rx_ready !== m_ready || bus.overrun !== m_ovr) begin bad++; $display("FAIL rand_%0d_flags: ready/ovr got %b/%b want %b/%b", f, bus.rx_ready, bus.overrun, m_ready, m_ovr); end
      total++; if (ferr_cnt !== m_ferr || bus.busy !== 1'b0) begin bad++; $display("FAIL rand_%0d_ferr_busy: ferr/busy got %0d/%b want %0d/0", f, ferr_cnt, bus.busy, m_ferr); end
      hold(1'b1, 3);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.rx_in   = 1'b1;
    bus.rx_en   = 1'b0;
    bus.read_en = 1'b0;
    #2 reset = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_break();
    test_overrun();
    test_same_cycle_read();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
